arbitro_rr_ctrl: RTL and testbench

- Central controller and arbiter between the four input FIFOs and the four output FIFOs of the transaction-layer switch.
- Owns the main state machine (RESET/INIT/IDLE/ACTIVE) and latches the shared FIFO thresholds.
- Round-robin grants one head-of-line word per cycle from a non-empty input FIFO to the output FIFO selected by data bits [9:8], back-pressured by output almost-full.
- Keeps per-output word counters, readable through a req/idx port.

---
 rtl/arbitro_rr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_arbitro_rr_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rr_ctrl
// Description : Central controller / arbiter for a 4x4 transaction-layer
//               switch. Runs the RESET/INIT/IDLE/ACTIVE state machine,
//               latches the shared FIFO thresholds while in INIT, and
//               round-robin grants one head-of-line word per cycle from a
//               non-empty input FIFO to the output FIFO named by the word's
//               destination field, honouring output almost-full. Keeps a
//               saturating word counter per output, readable via req/idx.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset (sync, active-high), init
//   umbral_bajo_in / umbral_alto_in : thresholds latched while in INIT
//   empty_in[3:0], data_in0..3      : input FIFO flags / FWFT head words
//   almost_full_out[3:0]            : output FIFO back-pressure
//   req, idx[1:0]                   : counter read request / index
//   pop_in[3:0]   (comb)            : one-hot pop to input FIFOs
//   push_out[3:0], data_out (reg)   : one-hot push + word to output FIFOs
//   umbral_bajo / umbral_alto       : latched thresholds
//   estado[3:0] {ACTIVE,IDLE,INIT,RESET}, idle
//   contador, valid                 : counter read data / qualifier
// Configuration macro:
//   ARB_FIXED_PRIO_EN : fixed priority 0>1>2>3 instead of round-robin
// ============================================================================
module arbitro_rr_ctrl #(
    parameter int DATA_W = 10,
    parameter int UMB_W  = 3,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [UMB_W-1:0]  umbral_bajo_in,
    input  logic [UMB_W-1:0]  umbral_alto_in,
    input  logic [3:0]        empty_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [3:0]        almost_full_out,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [3:0]        pop_in,
    output logic [3:0]        push_out,
    output logic [DATA_W-1:0] data_out,
    output logic [UMB_W-1:0]  umbral_bajo,
    output logic [UMB_W-1:0]  umbral_alto,
    output logic [3:0]        estado,
    output logic              idle,
    output logic [CNT_W-1:0]  contador,
    output logic              valid
);

    localparam logic [3:0] c_ST_RESET  = 4'b0001;
    localparam logic [3:0] c_ST_INIT   = 4'b0010;
    localparam logic [3:0] c_ST_IDLE   = 4'b0100;
    localparam logic [3:0] c_ST_ACTIVE = 4'b1000;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [3:0]        r_push;
    logic [DATA_W-1:0] r_data;
    logic [UMB_W-1:0]  r_umb_bajo;
    logic [UMB_W-1:0]  r_umb_alto;
    logic [CNT_W-1:0]  r_cnt [4];
    logic [CNT_W-1:0]  r_contador;
    logic              r_valid;

    logic [DATA_W-1:0] w_data [4];
    logic [1:0]        w_dest [4];
    logic [3:0]        w_elig;
    logic [1:0]        w_start;
    logic [1:0]        w_cand;
    logic [1:0]        w_grant_idx;
    logic              w_grant_found;
    logic              w_grant_en;

    assign w_data[0] = data_in0;
    assign w_data[1] = data_in1;
    assign w_data[2] = data_in2;
    assign w_data[3] = data_in3;

    // A requester is eligible only if its destination can still take a word.
    for (genvar g = 0; g < 4; g++) begin : g_elig
        assign w_dest[g] = w_data[g][DATA_W-1:DATA_W-2];
        assign w_elig[g] = ~empty_in[g] & ~almost_full_out[w_dest[g]];
    end

`ifdef ARB_FIXED_PRIO_EN
    assign w_start = 2'd0;
`else
    logic [1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`endif

    // First eligible requester scanning upward from w_start, wrapping at 4.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = 2'd0;
        w_cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = w_start + 2'(k);
            if (!w_grant_found && w_elig[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // init pre-empts granting in the same cycle it is seen in ACTIVE.
    assign w_grant_en = (r_state == c_ST_ACTIVE) && !init && !reset && w_grant_found;
    assign pop_in     = w_grant_en ? (4'b0001 << w_grant_idx) : 4'b0000;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_RESET:  w_next = init ? c_ST_INIT : c_ST_IDLE;
            c_ST_INIT:   w_next = init ? c_ST_INIT : c_ST_IDLE;
            c_ST_IDLE: begin
                if (init)
                    w_next = c_ST_INIT;
                else if (empty_in != 4'b1111)
                    w_next = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (init)
                    w_next = c_ST_INIT;
                else if (empty_in == 4'b1111)
                    w_next = c_ST_IDLE;
            end
            default:     w_next = c_ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_RESET;
            r_push     <= 4'b0000;
            r_data     <= '0;
            r_umb_bajo <= '0;
            r_umb_alto <= '0;
`ifndef ARB_FIXED_PRIO_EN
            r_rr_ptr   <= 2'd0;
`endif
        end else begin
            r_state <= w_next;
            r_push  <= 4'b0000;
            if (w_grant_en) begin
                r_push <= 4'b0001 << w_dest[w_grant_idx];
                r_data <= w_data[w_grant_idx];
`ifndef ARB_FIXED_PRIO_EN
                r_rr_ptr <= w_grant_idx + 2'd1;
`endif
            end
            if (r_state == c_ST_INIT) begin
                r_umb_bajo <= umbral_bajo_in;
                r_umb_alto <= umbral_alto_in;
            end
        end
    end

    // Counters advance on the cycle a push is presented, so a read issued on
    // the same edge sees the pre-increment value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                r_cnt[d] <= '0;
            end
            r_contador <= '0;
            r_valid    <= 1'b0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (r_push[d] && (r_cnt[d] != c_CNT_MAX)) begin
                    r_cnt[d] <= r_cnt[d] + 1'b1;
                end
            end
            if (req && (r_state != c_ST_RESET)) begin
                r_contador <= r_cnt[idx];
                r_valid    <= 1'b1;
            end else begin
                r_valid    <= 1'b0;
            end
        end
    end

    assign push_out    = r_push;
    assign data_out    = r_data;
    assign umbral_bajo = r_umb_bajo;
    assign umbral_alto = r_umb_alto;
    assign estado      = r_state;
    assign idle        = (r_state == c_ST_IDLE);
    assign contador    = r_contador;
    assign valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_rr_ctrl
// Description : Directed self-checking bench for arbitro_rr_ctrl. Input FIFOs
//               are modelled as bench queues (first-word-fall-through heads),
//               popped whenever the DUT asserts pop_in at a clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr_ctrl;

    localparam int DATA_W = 10;
    localparam int UMB_W  = 3;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic [UMB_W-1:0]  umbral_bajo_in;
    logic [UMB_W-1:0]  umbral_alto_in;
    logic [3:0]        empty_in;
    logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0]        almost_full_out;
    logic              req;
    logic [1:0]        idx;
    logic [3:0]        pop_in;
    logic [3:0]        push_out;
    logic [DATA_W-1:0] data_out;
    logic [UMB_W-1:0]  umbral_bajo;
    logic [UMB_W-1:0]  umbral_alto;
    logic [3:0]        estado;
    logic              idle;
    logic [CNT_W-1:0]  contador;
    logic              valid;

    always #5 clk = ~clk;

    arbitro_rr_ctrl #(.DATA_W(DATA_W), .UMB_W(UMB_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_bajo_in(umbral_bajo_in), .umbral_alto_in(umbral_alto_in),
        .empty_in(empty_in),
        .data_in0(data_in0), .data_in1(data_in1),
        .data_in2(data_in2), .data_in3(data_in3),
        .almost_full_out(almost_full_out),
        .req(req), .idx(idx),
        .pop_in(pop_in), .push_out(push_out), .data_out(data_out),
        .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
        .estado(estado), .idle(idle),
        .contador(contador), .valid(valid)
    );

    logic [DATA_W-1:0] q0[$], q1[$], q2[$], q3[$];
    logic [DATA_W-1:0] tmp;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        empty_in = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
        data_in0 = (q0.size() != 0) ? q0[0] : '0;
        data_in1 = (q1.size() != 0) ? q1[0] : '0;
        data_in2 = (q2.size() != 0) ? q2[0] : '0;
        data_in3 = (q3.size() != 0) ? q3[0] : '0;
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // One clock: pops sampled just before the edge, then FIFO heads refreshed.
    task automatic tick();
        logic [3:0] p;
        p = pop_in;
        @(posedge clk);
        #1;
        if (p[0]) tmp = q0.pop_front();
        if (p[1]) tmp = q1.pop_front();
        if (p[2]) tmp = q2.pop_front();
        if (p[3]) tmp = q3.pop_front();
        settle();
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (estado != 4'b0100 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, estado, 4'b0100);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; req = 1'b0; idx = 2'd0;
        umbral_bajo_in = '0; umbral_alto_in = '0; almost_full_out = 4'b0000;
        settle();

        // ---------------- reset and thresholds ----------------
        tick(); tick();
        chk("rst_estado", estado, 4'b0001);
        chk("rst_push", push_out, 4'b0000);
        chk("rst_data", data_out, 0);
        chk("rst_umb_bajo", umbral_bajo, 0);
        chk("rst_umb_alto", umbral_alto, 0);
        chk("rst_cont", contador, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pop", pop_in, 4'b0000);

        reset = 1'b0; init = 1'b1; umbral_bajo_in = 3'd1; umbral_alto_in = 3'd6;
        tick(); tick();
        chk("init_estado", estado, 4'b0010);
        chk("init_umb_bajo", umbral_bajo, 1);
        chk("init_umb_alto", umbral_alto, 6);
        init = 1'b0;
        tick();
        chk("idle_estado", estado, 4'b0100);
        chk("idle_flag", idle, 1);

        // ---------------- round-robin over four heads ----------------
        q0.push_back(10'h001); q1.push_back(10'h102);
        q2.push_back(10'h204); q3.push_back(10'h308);
        settle();
        chk("rr_idle_nopop", pop_in, 4'b0000);
        tick();
        chk("rr_active", estado, 4'b1000);
        chk("rr_pop0", pop_in, 4'b0001);
        tick();
        chk("rr_push0", push_out, 4'b0001);
        chk("rr_data0", data_out, 10'h001);
        chk("rr_pop1", pop_in, 4'b0010);
        tick();
        chk("rr_push1", push_out, 4'b0010);
        chk("rr_data1", data_out, 10'h102);
        chk("rr_pop2", pop_in, 4'b0100);
        tick();
        chk("rr_push2", push_out, 4'b0100);
        chk("rr_data2", data_out, 10'h204);
        chk("rr_pop3", pop_in, 4'b1000);
        tick();
        chk("rr_push3", push_out, 4'b1000);
        chk("rr_data3", data_out, 10'h308);
        chk("rr_pop_none", pop_in, 4'b0000);
        tick();
        chk("rr_back_idle", estado, 4'b0100);
        chk("rr_push_clear", push_out, 4'b0000);

        // ---------------- back-pressure ----------------
        almost_full_out = 4'b0001;
        q0.push_back(10'h001); q1.push_back(10'h102);
        settle();
        tick();
        chk("bp_skip0", pop_in, 4'b0010);
        tick();
        chk("bp_push1", push_out, 4'b0010);
        chk("bp_data1", data_out, 10'h102);
        chk("bp_stall", pop_in, 4'b0000);
        chk("bp_stay_active", estado, 4'b1000);
        almost_full_out = 4'b0000;
        settle();
        chk("bp_release", pop_in, 4'b0001);
        tick();
        chk("bp_push0", push_out, 4'b0001);
        chk("bp_data0", data_out, 10'h001);
        run_to_idle("bp_idle", 10);

        // ---------------- counters: fresh start, 4 words per output ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("cnt_pre_idle", estado, 4'b0100);
        for (int j = 0; j < 4; j++) begin
            q0.push_back({2'((0 + j) % 4), 8'(8'h00 + j)});
            q1.push_back({2'((1 + j) % 4), 8'(8'h10 + j)});
            q2.push_back({2'((2 + j) % 4), 8'(8'h20 + j)});
            q3.push_back({2'((3 + j) % 4), 8'(8'h30 + j)});
        end
        settle();
        tick();
        run_to_idle("cnt_drain", 40);
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            tick();
            chk($sformatf("cnt_read%0d", i), contador, 4);
            chk($sformatf("cnt_valid%0d", i), valid, 1);
        end
        req = 1'b0;
        tick();
        chk("cnt_valid_drop", valid, 0);
        chk("cnt_hold", contador, 4);

        // ---------------- saturation ----------------
        for (int j = 0; j < 33; j++) q2.push_back({2'd2, 8'(j)});
        settle();
        tick();
        run_to_idle("sat_drain", 60);
        req = 1'b1; idx = 2'd2;
        tick();
        req = 1'b0;
        chk("sat_cnt2", contador, 31);
        chk("sat_valid", valid, 1);

        // ---------------- reset mid-burst ----------------
        for (int j = 0; j < 5; j++) q0.push_back({2'd2, 8'(8'h40 + j)});
        settle();
        tick();
        tick();
        chk("mid_push", push_out, 4'b0100);
        reset = 1'b1;
        #1;
        chk("mid_pop_in_reset", pop_in, 4'b0000);
        tick();
        chk("mid_push_dropped", push_out, 4'b0000);
        chk("mid_estado", estado, 4'b0001);
        reset = 1'b0;
        q0.delete();
        settle();
        tick();
        chk("mid_idle", estado, 4'b0100);
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            tick();
            chk($sformatf("mid_cnt%0d", i), contador, 0);
            chk($sformatf("mid_valid%0d", i), valid, 1);
        end
        req = 1'b0;

        // ---------------- arbitration between FIFO0 and FIFO3 ----------------
        for (int j = 0; j < 6; j++) begin
            q0.push_back({2'd0, 8'(8'h50 + j)});
            q3.push_back({2'd3, 8'(8'h60 + j)});
        end
        settle();
        tick();
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk($sformatf("prio_pop%0d", k), pop_in, 4'b0001);
`else
            chk($sformatf("rr03_pop%0d", k), pop_in, (k % 2 == 0) ? 4'b0001 : 4'b1000);
`endif
            tick();
        end
        run_to_idle("final_idle", 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
